press_classifier: RTL and testbench

PRESS_CLASSIFIER -- requirements
Module: press_classifier

---
 rtl/press_classifier.sv | 167 ++++++++++++++++
 tb/tb_press_classifier.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/press_classifier.sv
// press_classifier: turns a debounced button level into short, long and
// double press events, plus a held level, a busy level and an event counter.
module press_classifier #(
    parameter int unsigned LONG_TICKS = 50000000,
    parameter int unsigned GAP_TICKS  = 12500000,
    parameter int unsigned CNT_WIDTH  = 26
) (
    input  logic       i_clk,
    input  logic       i_sclr,
    input  logic       i_in,
    output logic       o_short,
    output logic       o_long,
    output logic       o_double,
    output logic       o_held,
    output logic       o_busy,
    output logic [7:0] o_evcnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        GAP    = 3'd2,
        PRESS2 = 3'd3,
        HOLD   = 3'd4
    } state_e;

    localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(GAP_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] TIMER_ONE = CNT_WIDTH'(1);

    state_e               state_q;
    state_e               state_d;
    logic [CNT_WIDTH-1:0] timer_q;
    logic [CNT_WIDTH-1:0] timer_d;
    logic                 inDly_q;

    logic       short_q;
    logic       short_d;
    logic       long_q;
    logic       long_d;
    logic       double_q;
    logic       double_d;
    logic       held_q;
    logic       held_d;
    logic       busy_q;
    logic       busy_d;
    logic [7:0] evCnt_q;
    logic [7:0] evCnt_d;

    logic rise;
    logic fall;
    logic anyEvent;

    assign rise     = i_in & ~inDly_q;
    assign fall     = ~i_in & inDly_q;
    assign anyEvent = short_d | long_d | double_d;

    // State, timer and input-history registers; the history resets high so a
    // button held through reset must be released before it can count again.
    always_ff @(posedge i_clk) begin
        if (i_sclr) begin
            state_q <= IDLE;
            timer_q <= '0;
            inDly_q <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            inDly_q <= i_in;
        end
    end

    // Next-state, timer and event decode; the timer restarts on every state entry.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (rise) begin
                    state_d = PRESS1;
                end
            end

            PRESS1: begin
                if (fall) begin
                    state_d = GAP;
                    timer_d = '0;
                end else if (i_in && (timer_q == LONG_LAST)) begin
                    state_d = HOLD;
                    timer_d = '0;
                    long_d  = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end

            GAP: begin
                // A rise landing on the timeout cycle still counts as a second press.
                if (rise) begin
                    state_d = PRESS2;
                    timer_d = '0;
                end else if (timer_q == GAP_LAST) begin
                    state_d = IDLE;
                    timer_d = '0;
                    short_d = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end

            PRESS2: begin
                timer_d = '0;
                if (fall) begin
                    state_d  = IDLE;
                    double_d = 1'b1;
                end
            end

            HOLD: begin
                timer_d = '0;
                if (fall) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

        held_d  = (state_d == HOLD);
        busy_d  = (state_d != IDLE);
        evCnt_d = anyEvent ? (evCnt_q + 8'd1) : evCnt_q;
    end

    // Output registers; reset clears everything, discarding any pending event.
    always_ff @(posedge i_clk) begin
        if (i_sclr) begin
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            held_q   <= 1'b0;
            busy_q   <= 1'b0;
            evCnt_q  <= 8'd0;
        end else begin
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
            held_q   <= held_d;
            busy_q   <= busy_d;
            evCnt_q  <= evCnt_d;
        end
    end

    assign o_short  = short_q;
    assign o_long   = long_q;
    assign o_double = double_q;
    assign o_held   = held_q;
    assign o_busy   = busy_q;
    assign o_evcnt  = evCnt_q;

endmodule

// File: tb/tb_press_classifier.sv
// tb_press_classifier: directed gestures plus random press/release runs,
// compared every cycle against a run-length model of the classifier rules.
module tb_press_classifier;

    localparam int LONG_T = 8;
    localparam int GAP_T  = 4;

    logic       clk = 1'b0;
    logic       sclr = 1'b1;
    logic       inSig = 1'b0;
    logic       dutShort;
    logic       dutLong;
    logic       dutDouble;
    logic       dutHeld;
    logic       dutBusy;
    logic [7:0] dutEvCnt;

    int compareCount  = 0;
    int mismatchCount = 0;

    // Reference model: run lengths of the current press and release.
    bit mPrev;
    int mPress;
    int mHighLen;
    int mLowLen;
    bit mLongHeld;
    bit mShort;
    bit mLong;
    bit mDouble;
    int mEvCnt;

    int shortSeen;
    int longSeen;
    int doubleSeen;

    // Free-running clock.
    always #5 clk = ~clk;

    press_classifier #(
        .LONG_TICKS(LONG_T),
        .GAP_TICKS (GAP_T),
        .CNT_WIDTH (4)
    ) dut (
        .i_clk   (clk),
        .i_sclr  (sclr),
        .i_in    (inSig),
        .o_short (dutShort),
        .o_long  (dutLong),
        .o_double(dutDouble),
        .o_held  (dutHeld),
        .o_busy  (dutBusy),
        .o_evcnt (dutEvCnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // One sample of the rules: a press longer than LONG_T samples is long,
    // a release longer than GAP_T samples ends a single press, a second
    // press inside the window becomes a double on its release.
    task modelStep(input bit s, input bit v);
        mShort  = 1'b0;
        mLong   = 1'b0;
        mDouble = 1'b0;
        if (s) begin
            mPrev     = 1'b1;
            mPress    = 0;
            mHighLen  = 0;
            mLowLen   = 0;
            mLongHeld = 1'b0;
            mEvCnt    = 0;
        end else begin
            if (mLongHeld) begin
                if (!v) mLongHeld = 1'b0;
            end else if (mPress == 0) begin
                if (v && !mPrev) begin
                    mPress   = 1;
                    mHighLen = 1;
                    mLowLen  = 0;
                end
            end else if (mPress == 1 && mLowLen == 0) begin
                if (v) begin
                    mHighLen++;
                    if (mHighLen > LONG_T) begin
                        mLong     = 1'b1;
                        mLongHeld = 1'b1;
                        mPress    = 0;
                    end
                end else begin
                    mLowLen = 1;
                end
            end else if (mPress == 1) begin
                if (v) begin
                    mPress  = 2;
                    mLowLen = 0;
                end else begin
                    mLowLen++;
                    if (mLowLen > GAP_T) begin
                        mShort = 1'b1;
                        mPress = 0;
                    end
                end
            end else begin
                if (!v) begin
                    mDouble = 1'b1;
                    mPress  = 0;
                end
            end
            if (mShort || mLong || mDouble) mEvCnt = (mEvCnt + 1) % 256;
            mPrev = v;
        end
    endtask

    task automatic applyStimulus(input bit s, input bit v);
        sclr  = s;
        inSig = v;
        @(posedge clk);
        modelStep(s, v);
        #1;
        checkOutput("short",  32'(dutShort),  32'(mShort));
        checkOutput("long",   32'(dutLong),   32'(mLong));
        checkOutput("double", 32'(dutDouble), 32'(mDouble));
        checkOutput("held",   32'(dutHeld),   32'(mLongHeld));
        checkOutput("busy",   32'(dutBusy),   32'((mPress != 0) || mLongHeld));
        checkOutput("evcnt",  32'(dutEvCnt),  32'(mEvCnt));
        if (dutShort === 1'b1)  shortSeen++;
        if (dutLong === 1'b1)   longSeen++;
        if (dutDouble === 1'b1) doubleSeen++;
    endtask

    task automatic pressRelease(input int hi, input int lo);
        repeat (hi) applyStimulus(1'b0, 1'b1);
        repeat (lo) applyStimulus(1'b0, 1'b0);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        shortSeen  = 0;
        longSeen   = 0;
        doubleSeen = 0;
    endtask

    task automatic checkCounts(input string tag, input int s, input int l, input int d);
        checkOutput({tag, "_shorts"},  32'(shortSeen),  32'(s));
        checkOutput({tag, "_longs"},   32'(longSeen),   32'(l));
        checkOutput({tag, "_doubles"}, 32'(doubleSeen), 32'(d));
    endtask

    initial begin
        int hi;
        int lo;

        $display("[TB] start");
        doReset();
        checkOutput("rst_evcnt", 32'(dutEvCnt), 32'd0);

        pressRelease(3, 6);
        checkCounts("short", 1, 0, 0);
        checkOutput("short_evcnt", 32'(dutEvCnt), 32'd1);

        doReset();
        pressRelease(20, 6);
        checkCounts("long", 0, 1, 0);

        doReset();
        pressRelease(2, 2);
        pressRelease(2, 6);
        checkCounts("dbl2", 0, 0, 1);

        doReset();
        pressRelease(2, 4);
        pressRelease(2, 6);
        checkCounts("dbl4", 0, 0, 1);

        doReset();
        pressRelease(2, 5);
        pressRelease(2, 6);
        checkCounts("gap5", 2, 0, 0);

        doReset();
        pressRelease(8, 6);
        checkCounts("hi8", 1, 0, 0);

        doReset();
        pressRelease(9, 6);
        checkCounts("hi9", 0, 1, 0);

        doReset();
        pressRelease(3, 2);
        applyStimulus(1'b1, 1'b0);
        checkOutput("rst_gap_busy", 32'(dutBusy), 32'd0);
        repeat (6) applyStimulus(1'b0, 1'b0);
        checkCounts("rstgap", 0, 0, 0);

        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        shortSeen = 0; longSeen = 0; doubleSeen = 0;
        repeat (12) applyStimulus(1'b0, 1'b1);
        checkCounts("heldrst", 0, 0, 0);
        repeat (2) applyStimulus(1'b0, 1'b0);
        pressRelease(2, 6);
        checkCounts("heldrst2", 1, 0, 0);

        doReset();
        repeat (256) pressRelease(2, 6);
        checkOutput("wrap_shorts", 32'(shortSeen), 32'd256);
        checkOutput("wrap_evcnt", 32'(dutEvCnt), 32'd0);

        doReset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                applyStimulus(1'b1, 1'($urandom_range(0, 1)));
            end
            hi = int'($urandom_range(1, 12));
            lo = int'($urandom_range(1, 7));
            pressRelease(hi, lo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
